// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: frame-buffer read port plus VGA output bundle.
// master = the frame reader, slave = RAM / display side.
interface vga_frame_reader_if;
  logic [15:0] rddata;
  logic [14:0] rdaddr;
  logic        rden;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic        frame_start;

  modport master (
    input  rddata,
    output rdaddr, rden, vga_hsync, vga_vsync, vga_de,
           vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    output rddata,
    input  rdaddr, rden, vga_hsync, vga_vsync, vga_de,
           vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 timing generator that reads a 120x120 RGB565
// frame buffer and shows it 2^SCALE_LOG2 upscaled in a fixed screen window.
// Pipeline: S0 counters/decode -> S1 RAM address -> S2 RAM data -> S3 outputs.
// Optional macro FRAME_BORDER_EN paints the window outline white.
module vga_frame_reader #(
  parameter int WIDTH      = 120,
  parameter int HEIGHT     = 120,
  parameter int XOFF       = 200,
  parameter int YOFF       = 120,
  parameter int SCALE_LOG2 = 1
) (
  input  logic               clk,
  input  logic               reset,
  vga_frame_reader_if.master bus
);
  localparam int W  = WIDTH  << SCALE_LOG2;
  localparam int HH = HEIGHT << SCALE_LOG2;
  localparam logic [9:0] X0 = 10'(XOFF);
  localparam logic [9:0] X1 = 10'(XOFF + W);
  localparam logic [9:0] Y0 = 10'(YOFF);
  localparam logic [9:0] Y1 = 10'(YOFF + HH);
  localparam logic [9:0] XL = 10'(W - 1);
  localparam logic [9:0] YL = 10'(HH - 1);
`ifdef FRAME_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  // Control bits travelling down the pipe next to the RAM access.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic fs;
    logic bd;
  } ctl_t;
  localparam ctl_t CTL_IDLE = ctl_t'(6'b11_0000);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        in_win;
  logic [9:0]  lx, ly;
  logic [6:0]  img_x, img_y;
  ctl_t        c0, c1_q, c2_q;
  logic [14:0] rdaddr_q;
  logic        rden_q;
  logic        hs_q, vs_q, de_q, fs_q;
  logic [15:0] rgb_q;

  // Next raster position: h wraps at 799, v steps on h wrap and wraps at 524.
  always_comb begin
    h_d = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'd799) v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 0 decode: syncs, visible area, window membership and image coords.
  always_comb begin
    c0     = CTL_IDLE;
    in_win = (h_q >= X0) && (h_q < X1) && (v_q >= Y0) && (v_q < Y1);
    lx     = in_win ? h_q - X0 : 10'd0;
    ly     = in_win ? v_q - Y0 : 10'd0;
    img_x  = 7'(lx >> SCALE_LOG2);
    img_y  = 7'(ly >> SCALE_LOG2);
    c0.hs  = !((h_q >= 10'd656) && (h_q < 10'd752));
    c0.vs  = !((v_q >= 10'd490) && (v_q < 10'd492));
    c0.de  = (h_q < 10'd640) && (v_q < 10'd480);
    c0.win = in_win;
    c0.fs  = (h_q == 10'd0) && (v_q == 10'd0);
    c0.bd  = BORDER && in_win &&
             ((lx == 10'd0) || (lx == XL) || (ly == 10'd0) || (ly == YL));
  end

  // Stage 1: issue the RAM read; address is zero outside the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdaddr_q <= '0;
      rden_q   <= 1'b0;
      c1_q     <= CTL_IDLE;
    end else begin
      rdaddr_q <= in_win ? {img_y, img_x} : 15'd0;
      rden_q   <= in_win;
      c1_q     <= c0;
    end
  end

  // Stage 2: hold control while the RAM produces data.
  always_ff @(posedge clk) begin
    if (reset) c2_q <= CTL_IDLE;
    else       c2_q <= c1_q;
  end

  // Stage 3: registered outputs; black outside window or blanking, white border.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q <= c2_q.hs;
      vs_q <= c2_q.vs;
      de_q <= c2_q.de;
      fs_q <= c2_q.fs;
      if (!c2_q.de || !c2_q.win) rgb_q <= '0;
      else if (c2_q.bd)          rgb_q <= 16'hFFFF;
      else                       rgb_q <= bus.rddata;
    end
  end

  assign bus.rdaddr      = rdaddr_q;
  assign bus.rden        = rden_q;
  assign bus.vga_hsync   = hs_q;
  assign bus.vga_vsync   = vs_q;
  assign bus.vga_de      = de_q;
  assign bus.frame_start = fs_q;
  assign bus.vga_r       = rgb_q[15:11];
  assign bus.vga_g       = rgb_q[10:5];
  assign bus.vga_b       = rgb_q[4:0];
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: raster-position model checked every cycle, plus
// directed literal checks. A short window (YOFF=8, HEIGHT=24) keeps the
// whole image inside the first 56 lines so the run stays short.
module tb_vga_frame_reader;
  localparam int XOFF = 200;
  localparam int YOFF = 8;
  localparam int WID  = 120;
  localparam int HGT  = 24;
  localparam int SL   = 1;
  localparam int W    = WID << SL;
  localparam int HH   = HGT << SL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   started = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  vga_frame_reader_if bus ();

  vga_frame_reader #(
    .WIDTH(WID), .HEIGHT(HGT), .XOFF(XOFF), .YOFF(YOFF), .SCALE_LOG2(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data = address + 1 one cycle later, junk when not enabled.
  always @(posedge clk)
    bus.rddata <= bus.rden ? 16'(bus.rdaddr + 15'd1) : 16'hDEAD;

  // Raster position of the counters in the current cycle.
  always @(posedge clk) begin
    if (reset) begin
      cyc     <= 0;
      started <= 1'b1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  function automatic bit in_window(int h, int v);
    return h >= XOFF && h < XOFF + W && v >= YOFF && v < YOFF + HH;
  endfunction

  function automatic int ram_addr(int h, int v);
    return ((v - YOFF) / (1 << SL)) * 128 + (h - XOFF) / (1 << SL);
  endfunction

  // Expected {rden, rdaddr} for counter position pos (negative: pipeline empty).
  function automatic logic [15:0] model_rd(int pos);
    int h, v;
    if (pos < 0) return 16'h0;
    h = pos % 800;
    v = (pos / 800) % 525;
    if (!in_window(h, v)) return 16'h0;
    return {1'b1, 15'(ram_addr(h, v))};
  endfunction

  // Expected {hsync, vsync, de, frame_start, rgb565} for output pixel pos.
  function automatic logic [19:0] model_out(int pos);
    int h, v;
    logic hs, vs, de, fs;
    logic [15:0] col;
    if (pos < 0) return {1'b1, 1'b1, 1'b0, 1'b0, 16'h0};
    h   = pos % 800;
    v   = (pos / 800) % 525;
    hs  = !(h >= 656 && h < 752);
    vs  = !(v >= 490 && v < 492);
    de  = h < 640 && v < 480;
    fs  = (h == 0) && (v == 0);
    col = 16'h0;
    if (de && in_window(h, v)) begin
      col = 16'(ram_addr(h, v) + 1);
`ifdef FRAME_BORDER_EN
      if (h == XOFF || h == XOFF + W - 1 || v == YOFF || v == YOFF + HH - 1)
        col = 16'hFFFF;
`endif
    end
    return {hs, vs, de, fs, col};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] dut_out();
    return {bus.vga_hsync, bus.vga_vsync, bus.vga_de, bus.frame_start,
            bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk($sformatf("out@%0d", cyc), 32'(dut_out()), 32'(model_out(cyc - 3)));
      chk($sformatf("rd@%0d", cyc), 32'({bus.rden, bus.rdaddr}),
          32'(model_rd(cyc - 1)));
    end
  end

  task automatic wait_cyc(int c);
    int k = 0;
    while (cyc != c && k < 60000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != c) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_cyc: reached %0d required %0d", cyc, c);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_out", 32'(dut_out()), 32'h000C_0000);
    chk("reset_rd", 32'({bus.rden, bus.rdaddr}), 32'h0);
    reset = 1'b0;

    wait_cyc(2);   chk("fs_pre", 32'(bus.frame_start), 32'd0);
    wait_cyc(3);   chk("fs_first", 32'(bus.frame_start), 32'd1);
                   chk("de_first", 32'(bus.vga_de), 32'd1);
    wait_cyc(4);   chk("fs_once", 32'(bus.frame_start), 32'd0);
    wait_cyc(642); chk("de_last", 32'(bus.vga_de), 32'd1);
    wait_cyc(643); chk("de_off", 32'(bus.vga_de), 32'd0);
    wait_cyc(658); chk("hs_pre", 32'(bus.vga_hsync), 32'd1);
    wait_cyc(659); chk("hs_low", 32'(bus.vga_hsync), 32'd0);
    wait_cyc(754); chk("hs_end", 32'(bus.vga_hsync), 32'd0);
    wait_cyc(755); chk("hs_high", 32'(bus.vga_hsync), 32'd1);

    // Line 8 (first window row): address mapping and data alignment.
    wait_cyc(6600); chk("rd_199_8", 32'({bus.rden, bus.rdaddr}), 32'h0);
    wait_cyc(6601); chk("rd_200_8", 32'({bus.rden, bus.rdaddr}), 32'h8000);
    wait_cyc(6602); chk("rd_201_8", 32'({bus.rden, bus.rdaddr}), 32'h8000);
                    chk("col_199_8", 32'(dut_out() & 20'h0FFFF), 32'h0);
    wait_cyc(6603); chk("rd_202_8", 32'({bus.rden, bus.rdaddr}), 32'h8001);
`ifdef FRAME_BORDER_EN
                    chk("col_200_8", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFFF);
`else
                    chk("col_200_8", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0001);
`endif
    wait_cyc(7404); chk("col_201_9", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0001);
    wait_cyc(8201); chk("rd_200_10", 32'({bus.rden, bus.rdaddr}), 32'h8080);

    // Reset in the middle of a window line at (300,12).
    wait_cyc(9900);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out", 32'(dut_out()), 32'h000C_0000);
    chk("midrst_rd", 32'({bus.rden, bus.rdaddr}), 32'h0);
    reset = 1'b0;
    wait_cyc(2); chk("midrst_fs_pre", 32'(bus.frame_start), 32'd0);
    wait_cyc(3); chk("midrst_fs", 32'(bus.frame_start), 32'd1);

    // Bottom-right image pixel (439,55) -> {23,119}.
    wait_cyc(44440); chk("rd_439_55", 32'({bus.rden, bus.rdaddr}), 32'h8BF7);
    wait_cyc(44441); chk("rd_440_55", 32'({bus.rden, bus.rdaddr}), 32'h0);
`ifdef FRAME_BORDER_EN
    wait_cyc(44442); chk("col_439_55", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFFF);
`else
    wait_cyc(44442); chk("col_439_55", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0BF8);
`endif
    wait_cyc(45000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
